// File: rtl/lfm_phase_gen_if.sv
// lfm_phase_gen_if: control/status bundle between a chirp sequencer (master)
// and the linear-FM phase generator (slave). The clock and reset are not part
// of this bundle; they stay as plain ports on the generator.
interface lfm_phase_gen_if #(
  parameter int unsigned ACC_W   = 32,
  parameter int unsigned PHASE_W = 23,
  parameter int unsigned LEN_W   = 16
);
  // Requests and configuration from the sequencer.
  logic               start;
  logic               stop;
  logic               cont_mode;
  logic [ACC_W-1:0]   f_start;
  logic [ACC_W-1:0]   k_step;
  logic [LEN_W-1:0]   chirp_len;
  logic [LEN_W-1:0]   pri_len;

  // Phase address to the DDS and status back to the sequencer.
  logic [PHASE_W-1:0] rom_addr_reg;
  logic               tx_gate;
  logic               chirp_done;
  logic               pri_done;
  logic               busy;

  modport master (
    output start, stop, cont_mode, f_start, k_step, chirp_len, pri_len,
    input  rom_addr_reg, tx_gate, chirp_done, pri_done, busy
  );

  modport slave (
    input  start, stop, cont_mode, f_start, k_step, chirp_len, pri_len,
    output rom_addr_reg, tx_gate, chirp_done, pri_done, busy
  );
endinterface

// File: rtl/lfm_phase_gen.sv
// lfm_phase_gen: linear-FM (chirp) phase generator feeding a sin/cos DDS.
// Each pulse repetition interval (PRI) runs CHIRP samples, in which the phase
// accumulator advances by a frequency word that itself ramps by k_step per
// sample, followed by a silent GAP that pads the PRI out to pri_len cycles.
// The DDS phase address is the top PHASE_W bits of the accumulator.
//
// Optional build macro GATE_ALIGN_EN: when defined, tx_gate, chirp_done and
// pri_done pass through DDS_LAT extra registers so they line up with the DDS
// output samples; busy is never delayed. When undefined those outputs line up
// with rom_addr_reg.
module lfm_phase_gen #(
  parameter int unsigned ACC_W   = 32,
  parameter int unsigned PHASE_W = 23,
  parameter int unsigned LEN_W   = 16,
  parameter int unsigned DDS_LAT = 6
) (
  input  logic           sys_clk,
  input  logic           sys_rst_n,
  lfm_phase_gen_if.slave bus
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CHIRP = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  // One bit wider than the length inputs so that chirp_len+1 cannot overflow
  // when the minimum PRI is enforced.
  localparam int unsigned CNT_W = LEN_W + 1;

  logic [1:0]       state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] fcw_q, fcw_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Configuration captured on an accepted start.
  logic [ACC_W-1:0] f_start_q, f_start_d;
  logic [ACC_W-1:0] k_step_q, k_step_d;
  logic [CNT_W-1:0] chirp_len_q, chirp_len_d;
  logic [CNT_W-1:0] pri_len_q, pri_len_d;
  logic             cont_q, cont_d;

  logic             tx_gate_q, tx_gate_d;

  logic [CNT_W-1:0] eff_chirp;
  logic [CNT_W-1:0] eff_pri_min;
  logic [CNT_W-1:0] eff_pri;
  logic             chirp_last;
  logic             pri_last;
  logic             chirp_done_raw;
  logic             pri_done_raw;

  // Clamp the requested lengths: at least one chirp sample, and a PRI long
  // enough to leave at least one GAP cycle after the chirp.
  always_comb begin
    eff_chirp   = (bus.chirp_len == '0) ? CNT_W'(1) : {1'b0, bus.chirp_len};
    eff_pri_min = eff_chirp + CNT_W'(1);
    eff_pri     = ({1'b0, bus.pri_len} < eff_pri_min) ? eff_pri_min
                                                      : {1'b0, bus.pri_len};
  end

  // Terminal-count decode; a stop in the same cycle suppresses the pulses.
  always_comb begin
    chirp_last     = (cnt_q == (chirp_len_q - CNT_W'(1)));
    pri_last       = (cnt_q == (pri_len_q - CNT_W'(1)));
    chirp_done_raw = (state_q == ST_CHIRP) && chirp_last && !bus.stop;
    pri_done_raw   = (state_q == ST_GAP) && pri_last && !bus.stop;
  end

  // Sequencer next-state: IDLE -> CHIRP -> GAP -> (CHIRP | IDLE); stop overrides.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    fcw_d       = fcw_q;
    cnt_d       = cnt_q;
    f_start_d   = f_start_q;
    k_step_d    = k_step_q;
    chirp_len_d = chirp_len_q;
    pri_len_d   = pri_len_q;
    cont_d      = cont_q;

    case (state_q)
      ST_IDLE: begin
        acc_d = '0;
        if (bus.start && !bus.stop) begin
          f_start_d   = bus.f_start;
          k_step_d    = bus.k_step;
          chirp_len_d = eff_chirp;
          pri_len_d   = eff_pri;
          cont_d      = bus.cont_mode;
          fcw_d       = bus.f_start;
          cnt_d       = '0;
          state_d     = ST_CHIRP;
        end
      end

      ST_CHIRP: begin
        acc_d = acc_q + fcw_q;
        fcw_d = fcw_q + k_step_q;
        cnt_d = cnt_q + CNT_W'(1);
        if (chirp_last) begin
          acc_d   = '0;
          state_d = ST_GAP;
        end
      end

      ST_GAP: begin
        acc_d = '0;
        cnt_d = cnt_q + CNT_W'(1);
        if (pri_last) begin
          cnt_d = '0;
          if (cont_q) begin
            fcw_d   = f_start_q;
            state_d = ST_CHIRP;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end

      default: begin
        acc_d   = '0;
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase

    if (bus.stop) begin
      acc_d   = '0;
      fcw_d   = '0;
      cnt_d   = '0;
      state_d = ST_IDLE;
    end
  end

  // Gate is registered from the next state so it leaves the flop alongside acc.
  always_comb begin
    tx_gate_d = (state_d == ST_CHIRP);
  end

  // State, datapath and configuration registers with synchronous reset.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q     <= ST_IDLE;
      acc_q       <= '0;
      fcw_q       <= '0;
      cnt_q       <= '0;
      f_start_q   <= '0;
      k_step_q    <= '0;
      chirp_len_q <= '0;
      pri_len_q   <= '0;
      cont_q      <= 1'b0;
      tx_gate_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      fcw_q       <= fcw_d;
      cnt_q       <= cnt_d;
      f_start_q   <= f_start_d;
      k_step_q    <= k_step_d;
      chirp_len_q <= chirp_len_d;
      pri_len_q   <= pri_len_d;
      cont_q      <= cont_d;
      tx_gate_q   <= tx_gate_d;
    end
  end

  assign bus.rom_addr_reg = acc_q[ACC_W-1 -: PHASE_W];
  assign bus.busy         = (state_q != ST_IDLE);

`ifdef GATE_ALIGN_EN
  logic [DDS_LAT-1:0] gate_dly_q, gate_dly_d;
  logic [DDS_LAT-1:0] cdone_dly_q, cdone_dly_d;
  logic [DDS_LAT-1:0] pdone_dly_q, pdone_dly_d;

  // Shift each strobe one stage; the truncating cast keeps this valid for DDS_LAT=1.
  always_comb begin
    gate_dly_d  = DDS_LAT'({gate_dly_q, tx_gate_q});
    cdone_dly_d = DDS_LAT'({cdone_dly_q, chirp_done_raw});
    pdone_dly_d = DDS_LAT'({pdone_dly_q, pri_done_raw});
  end

  // Delay lines matching the DDS pipeline latency.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      gate_dly_q  <= '0;
      cdone_dly_q <= '0;
      pdone_dly_q <= '0;
    end else begin
      gate_dly_q  <= gate_dly_d;
      cdone_dly_q <= cdone_dly_d;
      pdone_dly_q <= pdone_dly_d;
    end
  end

  assign bus.tx_gate    = gate_dly_q[DDS_LAT-1];
  assign bus.chirp_done = cdone_dly_q[DDS_LAT-1];
  assign bus.pri_done   = pdone_dly_q[DDS_LAT-1];
`else
  logic unused_dds_lat;
  assign unused_dds_lat = (DDS_LAT != 0);

  assign bus.tx_gate    = tx_gate_q;
  assign bus.chirp_done = chirp_done_raw;
  assign bus.pri_done   = pri_done_raw;
`endif

endmodule

// File: tb/tb_lfm_phase_gen.sv
// tb_lfm_phase_gen: directed chirp sequences with hand-computed DDS addresses.
// The driver pushes per-cycle expectations into two queues (address/busy, and
// gate/done strobes offset by the gate alignment latency); a negedge monitor
// pops and compares them against the DUT.
module tb_lfm_phase_gen;

`ifdef GATE_ALIGN_EN
  localparam int unsigned LAT = 6;
`else
  localparam int unsigned LAT = 0;
`endif

  logic        sys_clk;
  logic        sys_rst_n;
  int unsigned cyc = 0;

  lfm_phase_gen_if #(.ACC_W(32), .PHASE_W(23), .LEN_W(16)) bus ();

  lfm_phase_gen #(
    .ACC_W  (32),
    .PHASE_W(23),
    .LEN_W  (16),
    .DDS_LAT(6)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .bus      (bus)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned at;
    logic [22:0] rom;
    logic        busy;
  } addr_rec_t;

  typedef struct {
    int unsigned at;
    logic        gate;
    logic        cd;
    logic        pd;
  } flag_rec_t;

  addr_rec_t aq[$];
  flag_rec_t fq[$];

  int unsigned errors = 0;
  int unsigned checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  // Monitor: compare every expectation stamped for the current cycle.
  always @(negedge sys_clk) begin
    addr_rec_t ar;
    flag_rec_t fr;
    while (aq.size() > 0 && aq[0].at <= cyc) begin
      ar = aq.pop_front();
      if (ar.at < cyc) begin
        checks++;
        errors++;
        $display("FAIL addr_missed stamp=%0d now=%0d", ar.at, cyc);
      end else begin
        chk("rom_addr_reg", 32'(bus.rom_addr_reg), 32'(ar.rom));
        chk("busy", 32'(bus.busy), 32'(ar.busy));
      end
    end
    while (fq.size() > 0 && fq[0].at <= cyc) begin
      fr = fq.pop_front();
      if (fr.at < cyc) begin
        checks++;
        errors++;
        $display("FAIL flag_missed stamp=%0d now=%0d", fr.at, cyc);
      end else begin
        chk("tx_gate", 32'(bus.tx_gate), 32'(fr.gate));
        chk("chirp_done", 32'(bus.chirp_done), 32'(fr.cd));
        chk("pri_done", 32'(bus.pri_done), 32'(fr.pd));
      end
    end
  end

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  // Expect these outputs in the current cycle, then advance one cycle.
  task automatic step(input logic [22:0] rom, input logic g, input logic cd,
                      input logic pd, input logic b);
    aq.push_back('{at: cyc, rom: rom, busy: b});
    fq.push_back('{at: cyc + LAT, gate: g, cd: cd, pd: pd});
    tick();
  endtask

  // Reset asserted for this cycle: strobes still in flight in a delay line are cleared.
  task automatic reset_step(input logic [22:0] rom, input logic g, input logic cd,
                            input logic pd, input logic b);
    sys_rst_n = 1'b0;
    aq.push_back('{at: cyc, rom: rom, busy: b});
    fq.push_back('{at: cyc + LAT, gate: g, cd: cd, pd: pd});
    for (int i = 0; i < fq.size(); i++) begin
      if (fq[i].at > cyc) begin
        fq[i].gate = 1'b0;
        fq[i].cd   = 1'b0;
        fq[i].pd   = 1'b0;
      end
    end
    tick();
    sys_rst_n = 1'b1;
  endtask

  task automatic cfg(input logic [31:0] f, input logic [31:0] k, input logic [15:0] cl,
                     input logic [15:0] pl, input logic cm);
    bus.f_start   = f;
    bus.k_step    = k;
    bus.chirp_len = cl;
    bus.pri_len   = pl;
    bus.cont_mode = cm;
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) step(23'h0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    sys_rst_n = 1'b0;
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    cfg(32'h0, 32'h0, 16'd0, 16'd0, 1'b0);
    tick();

    // Reset state
    idle(2);
    sys_rst_n = 1'b1;
    idle(1);

    // 1: constant FCW, config changes while busy must not matter
    cfg(32'h0100_0000, 32'h0, 16'd4, 16'd8, 1'b0);
    bus.start = 1'b1;
    idle(1);
    bus.start = 1'b0;
    cfg(32'hDEAD_BEEF, 32'h0000_1234, 16'd2, 16'd3, 1'b1);
    step(23'h000000, 1, 0, 0, 1);
    step(23'h008000, 1, 0, 0, 1);
    step(23'h010000, 1, 0, 0, 1);
    step(23'h018000, 1, 1, 0, 1);
    step(23'h000000, 0, 0, 0, 1);
    step(23'h000000, 0, 0, 0, 1);
    step(23'h000000, 0, 0, 0, 1);
    step(23'h000000, 0, 0, 1, 1);
    idle(2);

    // 2: FCW ramp from zero
    cfg(32'h0, 32'h0000_0200, 16'd4, 16'd5, 1'b0);
    bus.start = 1'b1;
    idle(1);
    bus.start = 1'b0;
    step(23'h000000, 1, 0, 0, 1);
    step(23'h000000, 1, 0, 0, 1);
    step(23'h000001, 1, 0, 0, 1);
    step(23'h000003, 1, 1, 0, 1);
    step(23'h000000, 0, 0, 1, 1);
    idle(2);

    // 3: accumulator wrap through the quadrant bits
    cfg(32'h8000_0000, 32'h0, 16'd4, 16'd5, 1'b0);
    bus.start = 1'b1;
    idle(1);
    bus.start = 1'b0;
    step(23'h000000, 1, 0, 0, 1);
    step(23'h400000, 1, 0, 0, 1);
    step(23'h000000, 1, 0, 0, 1);
    step(23'h400000, 1, 1, 0, 1);
    step(23'h000000, 0, 0, 1, 1);
    idle(2);

    // 4: continuous PRIs, stop on the last chirp sample of PRI 3
    cfg(32'h0100_0000, 32'h0080_0000, 16'd3, 16'd6, 1'b1);
    bus.start = 1'b1;
    idle(1);
    bus.start = 1'b0;
    for (int p = 0; p < 2; p++) begin
      step(23'h000000, 1, 0, 0, 1);
      step(23'h008000, 1, 0, 0, 1);
      step(23'h014000, 1, 1, 0, 1);
      step(23'h000000, 0, 0, 0, 1);
      step(23'h000000, 0, 0, 0, 1);
      step(23'h000000, 0, 0, 1, 1);
    end
    step(23'h000000, 1, 0, 0, 1);
    step(23'h008000, 1, 0, 0, 1);
    bus.stop = 1'b1;
    step(23'h014000, 1, 0, 0, 1);
    bus.stop = 1'b0;
    idle(2);

    // 5: zero lengths clamp to 1 chirp + 1 gap; start during GAP ignored
    cfg(32'h0100_0000, 32'h0, 16'd0, 16'd0, 1'b0);
    bus.start = 1'b1;
    idle(1);
    bus.start = 1'b0;
    step(23'h000000, 1, 1, 0, 1);
    bus.start = 1'b1;
    step(23'h000000, 0, 0, 1, 1);
    bus.start = 1'b0;
    idle(2);
    // start and stop together while idle: stop wins
    bus.start = 1'b1;
    bus.stop  = 1'b1;
    idle(1);
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    idle(2);

    // 6: synchronous reset mid-chirp
    cfg(32'h0100_0000, 32'h0, 16'd4, 16'd8, 1'b0);
    bus.start = 1'b1;
    idle(1);
    bus.start = 1'b0;
    step(23'h000000, 1, 0, 0, 1);
    step(23'h008000, 1, 0, 0, 1);
    reset_step(23'h010000, 1, 0, 0, 1);
    idle(LAT + 3);

    // Let any delayed strobe expectations drain, then confirm nothing is left.
    for (int unsigned i = 0; i < LAT + 2; i++) tick();
    checks++;
    if (aq.size() != 0 || fq.size() != 0) begin
      errors++;
      $display("FAIL queue_drain addr_left=%0d flag_left=%0d expected=0", aq.size(), fq.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lfm_phase_gen.md
Name: lfm_phase_gen

Overview:
Linear-FM (chirp) phase generator directly upstream of the sin/cos DDS stage.
- Drives the DDS's 23-bit phase address input: bits [22:21] quadrant, [20:13] coarse, [12:5] fine, [4:0] Taylor.
- Produces pulsed radar chirps: frequency control word ramps by a programmable step per sample, then a silent gap fills out the pulse repetition interval (PRI).
- Supports single-shot or continuous PRI repetition.

Parameters:
ACC_W, 32, phase accumulator and frequency-word width
PHASE_W, 23, output phase address width (top PHASE_W bits of accumulator)
LEN_W, 16, width of chirp/PRI length counters
DDS_LAT, 6, DDS pipeline latency in cycles (used only with GATE_ALIGN_EN)

Ports:
sys_clk  in  1  system clock, all logic on rising edge
sys_rst_n  in  1  synchronous active-low reset
start  in  1  one-cycle request to begin a chirp sequence; ignored unless IDLE
stop  in  1  synchronous abort; returns to IDLE next edge
cont_mode  in  1  1 = repeat PRIs until stop; 0 = single PRI; sampled at start
f_start  in  ACC_W  initial frequency control word; sampled at start
k_step  in  ACC_W  per-sample FCW increment (two's-complement, mod 2^ACC_W); sampled at start
chirp_len  in  LEN_W  chirp samples per PRI; sampled at start
pri_len  in  LEN_W  PRI length in cycles; sampled at start
rom_addr_reg  out  PHASE_W  phase address to DDS = acc[ACC_W-1 -: PHASE_W]
tx_gate  out  1  high during CHIRP samples
chirp_done  out  1  one-cycle pulse on last CHIRP cycle
pri_done  out  1  one-cycle pulse on last GAP cycle
busy  out  1  high when state != IDLE

Behaviour:
- Reset (sys_rst_n=0 at edge): state=IDLE; acc, fcw, counters, latched configuration = 0; all outputs 0. Reset mid-operation aborts immediately, with no completion pulses.
- States: IDLE, CHIRP, GAP.
- IDLE:
  - acc=0, rom_addr_reg=0.
  - On start=1 and stop=0: latch config; fcw<=f_start; acc<=0; cnt<=0; next=CHIRP.
- Clamping at latch:
  - chirp_len==0 treated as 1.
  - pri_len < eff_chirp_len+1 treated as eff_chirp_len+1, so GAP is always at least one cycle.
- CHIRP, each cycle:
  - acc<=acc+fcw; fcw<=fcw+k_step (both wrap mod 2^ACC_W); cnt<=cnt+1; tx_gate=1.
  - First CHIRP cycle presents rom_addr_reg=0.
  - When cnt==eff_chirp_len-1: chirp_done=1; next=GAP.
- GAP:
  - acc held 0, rom_addr_reg=0, tx_gate=0; cnt continues counting from PRI start.
  - When cnt==eff_pri_len-1: pri_done=1.
    - cont_mode_latched=1: reload fcw<=f_start_latched, acc<=0, cnt<=0; next=CHIRP.
    - Otherwise: next=IDLE.
- rom_addr_reg and tx_gate are taken directly from registers, with no combinational path from inputs.
- stop=1 in any state: next=IDLE, acc/fcw cleared, no done pulses that cycle. stop and start in the same cycle: stop wins.
- start while busy: ignored; latched configuration unchanged.
- Config input changes while busy have no effect until the next start.
- Phase wrap: acc overflow is silent modular wrap; the quadrant bits cycle naturally.

Optional Feature:
GATE_ALIGN_EN
- Defined: tx_gate, chirp_done and pri_done are delayed by DDS_LAT registers (reset to 0) so they align with the DDS output samples. busy stays undelayed.
- Undefined: these outputs align with rom_addr_reg, zero added latency.

Test Plan:
1. f_start=32'h0100_0000, k_step=0, chirp_len=4, pri_len=8, cont_mode=0, start:
   - rom_addr_reg = 0, 0x008000, 0x010000, 0x018000; then 0 for 4 GAP cycles.
   - tx_gate high exactly 4 cycles; chirp_done on 4th; pri_done on 8th; busy drops after.
2. f_start=0, k_step=32'h200, chirp_len=4, pri_len=5: rom_addr_reg = 0, 0, 1, 3, then 0; fcw ramp verified.
3. Wrap: f_start=32'h8000_0000, k_step=0, chirp_len=4: rom_addr_reg = 0, 0x400000, 0, 0x400000.
4. cont_mode=1, chirp_len=3, pri_len=6:
   - Three consecutive PRIs show an identical address sequence, with chirp restarting at the same acc=0 phase.
   - stop asserted mid-chirp in PRI 3: IDLE next edge, outputs 0, no done pulse.
5. chirp_len=0, pri_len=0: one CHIRP cycle, one GAP cycle.
   - start reasserted during GAP is ignored.
   - start+stop in the same IDLE cycle stays in IDLE.
6. sys_rst_n=0 for one cycle mid-CHIRP: all outputs 0 next edge, state IDLE.
   - With GATE_ALIGN_EN: repeat test 1; tx_gate rises 6 cycles after the first CHIRP cycle.
